// File: rtl/rv32i_inst_pkg.sv
// Shared RV32I definitions: the canonical NOP encoding and the fetch-group
// bundle passed from IF to ID.
package RV32I_Inst_Pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

  // Widest fetch group the front end produces; narrower configs use the low lanes.
  localparam int FG_LANES = 2;
  localparam int FG_XLEN  = 32;

  typedef struct packed {
    logic [FG_LANES-1:0][FG_XLEN-1:0] instr;
    logic [FG_LANES-1:0][FG_XLEN-1:0] addr;
    logic [FG_LANES-1:0]              lane_valid;
  } fetch_group_t;

endpackage

// File: rtl/if_id_queue_ctrl.sv
// Occupancy and pointer bookkeeping for the IF/ID queue. Flush returns to the
// empty state and drops any same-cycle push or pop.
module if_id_queue_ctrl #(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign wr_ptr = wr_ptr_reg;
  assign rd_ptr = rd_ptr_reg;
  assign count  = count_reg;

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: holds up to DEPTH fetch groups and presents the head
// group to decode, substituting NOPs for invalid lanes and empty cycles.
module if_id_queue
  import RV32I_Inst_Pkg::*;
#(
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*XLEN-1:0] instr_if,
  input  logic [LANES*XLEN-1:0] instr_addr_if,
  input  logic [LANES-1:0]      lane_valid_if,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] instr_if_id,
  output logic [LANES*XLEN-1:0] instr_addr_if_id,
  output logic [LANES-1:0]      lane_valid_if_id,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  logic [LANES*XLEN-1:0] instr_mem      [DEPTH];
  logic [LANES*XLEN-1:0] addr_mem       [DEPTH];
  logic [LANES-1:0]      lane_valid_mem [DEPTH];

  logic [LANES*XLEN-1:0] head_instr;
  logic [LANES*XLEN-1:0] head_addr;
  logic [LANES-1:0]      head_lane_valid;

  // Reset masks the outputs combinationally so the empty view holds during reset too.
  assign in_ready  = rst_sync || (count_q < CNT_W'(DEPTH));
  assign out_valid = !rst_sync && (count_q != '0);
  assign count     = rst_sync ? '0 : count_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  if_id_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk      (clk),
    .rst_sync (rst_sync),
    .flush    (flush),
    .push     (push),
    .pop      (pop),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .count    (count_q)
  );

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i]      <= '0;
        addr_mem[i]       <= '0;
        lane_valid_mem[i] <= '0;
      end
    end else if (push && !flush) begin
      instr_mem[wr_ptr]      <= instr_if;
      addr_mem[wr_ptr]       <= instr_addr_if;
      lane_valid_mem[wr_ptr] <= lane_valid_if;
    end
  end

  assign head_instr      = instr_mem[rd_ptr];
  assign head_addr       = addr_mem[rd_ptr];
  assign head_lane_valid = lane_valid_mem[rd_ptr];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign instr_if_id[gi*XLEN +: XLEN] = (out_valid && head_lane_valid[gi])
                                          ? head_instr[gi*XLEN +: XLEN]
                                          : XLEN'(INST_NOP);
    end
  endgenerate

  // Addresses are never bubbled; they always track the slot at the read pointer.
  assign instr_addr_if_id = rst_sync ? '0 : head_addr;
  assign lane_valid_if_id = out_valid ? head_lane_valid : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: a LANES=2/DEPTH=2 instance for reset, fill,
// push/pop, flush and partial-group cases, and a DEPTH=4 instance for wrap-around.
module tb_if_id_queue;
  import RV32I_Inst_Pkg::*;

  localparam logic [63:0] NOP2 = 64'h0000_0013_0000_0013;

  logic        clk = 1'b0;
  logic        rst_sync, flush, in_valid;
  logic [63:0] instr_if, instr_addr_if;
  logic [1:0]  lane_valid_if;

  logic        out_ready_a, in_ready_a, out_valid_a;
  logic [63:0] instr_a, addr_a;
  logic [1:0]  lv_a, count_a;

  logic        out_ready_b, in_ready_b, out_valid_b;
  logic [63:0] instr_b, addr_b;
  logic [1:0]  lv_b;
  logic [2:0]  count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_queue #(.LANES(2), .DEPTH(2), .XLEN(32)) dut_a (
    .clk(clk), .rst_sync(rst_sync), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .instr_if(instr_if), .instr_addr_if(instr_addr_if), .lane_valid_if(lane_valid_if),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .instr_if_id(instr_a), .instr_addr_if_id(addr_a), .lane_valid_if_id(lv_a),
    .count(count_a)
  );

  if_id_queue #(.LANES(2), .DEPTH(4), .XLEN(32)) dut_b (
    .clk(clk), .rst_sync(rst_sync), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .instr_if(instr_if), .instr_addr_if(instr_addr_if), .lane_valid_if(lane_valid_if),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .instr_if_id(instr_b), .instr_addr_if_id(addr_b), .lane_valid_if_id(lv_b),
    .count(count_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_group_t mk(input logic [31:0] pc, input logic [31:0] i0,
                                      input logic [31:0] i1, input logic [1:0] lv);
    fetch_group_t g;
    g.instr[0]   = i0;
    g.instr[1]   = i1;
    g.addr[0]    = pc;
    g.addr[1]    = pc + 32'd4;
    g.lane_valid = lv;
    return g;
  endfunction

  task automatic drive(input logic v, input fetch_group_t g);
    in_valid      = v;
    instr_if      = g.instr;
    instr_addr_if = g.addr;
    lane_valid_if = g.lane_valid;
    if (v) $display("drive pc=%h lv=%b", g.addr[0], g.lane_valid);
  endtask

  localparam logic [31:0] I0 = 32'h00a0_0093;
  localparam logic [31:0] I1 = 32'h00b0_0113;

  initial begin
    fetch_group_t g;
    logic [31:0]  q[$];
    logic [31:0]  pc;
    logic         push_ok, pop_ok;
    int           pushed, popped, cyc;

    rst_sync = 1'b1; flush = 1'b0; out_ready_a = 1'b0; out_ready_b = 1'b0;
    drive(1'b1, mk(32'h0000_0ff0, I0, I1, 2'b11));

    // Reset with in_valid high
    tick();
    check("rst_count",     count_a, 0);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_instr",     instr_a, NOP2);
    check("rst_in_ready",  in_ready_a, 1);
    check("rst_lv",        lv_a, 0);
    check("rst_addr",      addr_a, 0);
    rst_sync = 1'b0;
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    #1;
    check("post_rst_count", count_a, 0);
    check("post_rst_instr", instr_a, NOP2);
    check("post_rst_addr",  addr_a, 0);
    tick();

    // Fill and drain
    drive(1'b1, mk(32'h100, I0, I1, 2'b11));
    tick();
    check("fill1_count", count_a, 1);
    check("fill1_valid", out_valid_a, 1);
    check("fill1_addr",  addr_a, 64'h0000_0104_0000_0100);
    check("fill1_instr", instr_a, {I1, I0});
    drive(1'b1, mk(32'h108, 32'h0010_0013, 32'h0020_0013, 2'b11));
    tick();
    check("fill2_count",    count_a, 2);
    check("fill2_in_ready", in_ready_a, 0);
    drive(1'b1, mk(32'h110, 32'h0030_0013, 32'h0040_0013, 2'b11));
    tick();
    check("full_push_count", count_a, 2);
    check("full_push_head",  addr_a[31:0], 32'h100);
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    out_ready_a = 1'b1;
    tick();
    check("drain1_head",  addr_a[31:0], 32'h108);
    check("drain1_instr", instr_a, 64'h0020_0013_0010_0013);
    check("drain1_count", count_a, 1);
    tick();
    check("drain2_count", count_a, 0);
    check("drain2_valid", out_valid_a, 0);
    check("drain2_instr", instr_a, NOP2);
    check("drain2_addr",  addr_a[31:0], 32'h100);
    out_ready_a = 1'b0;

    // Simultaneous push and pop at count=1
    drive(1'b1, mk(32'h1f0, I0, I1, 2'b11));
    tick();
    drive(1'b1, mk(32'h200, I0, I1, 2'b11));
    out_ready_a = 1'b1;
    tick();
    check("pp_count", count_a, 1);
    check("pp_head",  addr_a[31:0], 32'h200);
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    tick();
    check("pp_drain_count", count_a, 0);
    out_ready_a = 1'b0;

    // Flush a full queue while IF presents another group
    drive(1'b1, mk(32'h300, I0, I1, 2'b11));
    tick();
    drive(1'b1, mk(32'h308, I0, I1, 2'b11));
    tick();
    check("pre_flush_count", count_a, 2);
    drive(1'b1, mk(32'h310, I0, I1, 2'b11));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    check("flush_count", count_a, 0);
    check("flush_valid", out_valid_a, 0);
    check("flush_instr", instr_a, NOP2);
    check("flush_lv",    lv_a, 0);
    check("flush_in_rdy", in_ready_a, 1);

    // Flush at count=1 with an acceptable push and a pop in the same cycle
    drive(1'b1, mk(32'h400, I0, I1, 2'b11));
    tick();
    check("after_flush_head", addr_a[31:0], 32'h400);
    drive(1'b1, mk(32'h408, I0, I1, 2'b11));
    out_ready_a = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready_a = 1'b0;
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    check("flush_pp_count", count_a, 0);
    check("flush_pp_valid", out_valid_a, 0);
    check("flush_keeps_mem", addr_a[31:0], 32'h400);

    // Flush on an empty queue
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty_count", count_a, 0);
    check("flush_empty_rdy",   in_ready_a, 1);

    // Partial group: only lane 1 valid
    drive(1'b1, mk(32'h500, I0, I1, 2'b10));
    tick();
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    check("partial_instr", instr_a, {I1, INST_NOP});
    check("partial_addr",  addr_a, 64'h0000_0504_0000_0500);
    check("partial_lv",    lv_a, 2'b10);
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    check("partial_pop_count", count_a, 0);

    // Wrap-around on the DEPTH=4 instance with random stalls
    rst_sync = 1'b1;
    tick();
    rst_sync = 1'b0;
    check("b_rst_count", count_b, 0);
    pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 7 || q.size() > 0) && cyc < 200) begin
      pc = 32'h600 + 32'(pushed) * 32'd8;
      drive(pushed < 7, mk(pc, I0 + 32'(pushed), I1, 2'b11));
      out_ready_b = ($urandom_range(0, 2) != 0);
      #1;
      check("wrap_in_ready",  in_ready_b, (q.size() < 4) ? 1 : 0);
      check("wrap_out_valid", out_valid_b, (q.size() != 0) ? 1 : 0);
      if (q.size() > 0) check("wrap_head", addr_b[31:0], q[0]);
      push_ok = (pushed < 7) && (q.size() < 4);
      pop_ok  = out_ready_b && (q.size() > 0);
      tick();
      if (pop_ok) begin
        $display("pop  pc=%h", q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (push_ok) begin
        q.push_back(pc);
        pushed++;
      end
      cyc++;
    end
    drive(1'b0, mk(32'h0, 32'h0, 32'h0, 2'b00));
    out_ready_b = 1'b0;
    check("wrap_popped",  popped, 7);
    check("wrap_pushed",  pushed, 7);
    check("wrap_timeout", (cyc < 200) ? 1 : 0, 1);
    #1;
    check("wrap_count",   count_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter LANES, 1, instructions per fetch group; legal values 1 or 2.
REQ-002 Parameter DEPTH, 2, fetch groups held; power of two, at least 2.
REQ-003 Parameter XLEN, 32, instruction and address width.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst_sync, input, 1, synchronous active-high reset.
REQ-006 Port flush, input, 1, squash all held groups (branch or exception redirect).
REQ-007 Port in_valid, input, 1, IF presents a fetch group.
REQ-008 Port in_ready, output, 1, queue accepts a group this cycle.
REQ-009 Port instr_if, input, LANES x XLEN, instruction per lane.
REQ-010 Port instr_addr_if, input, LANES x XLEN, PC per lane.
REQ-011 Port lane_valid_if, input, LANES, per-lane valid bit, for a partial group at a misaligned target.
REQ-012 Port out_valid, output, 1, head group available to ID.
REQ-013 Port out_ready, input, 1, ID consumes the head group.
REQ-014 Port instr_if_id, output, LANES x XLEN, head instruction per lane.
REQ-015 Port instr_addr_if_id, output, LANES x XLEN, head PC per lane.
REQ-016 Port lane_valid_if_id, output, LANES, head per-lane valid.
REQ-017 Port count, output, clog2(DEPTH+1), number of groups held.

Function
REQ-018 A push SHALL occur when in_valid and in_ready are both 1 at a rising edge. A pop SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-019 in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on out_ready. A full queue does not accept a push, even in a cycle that pops.
REQ-020 out_valid SHALL equal (count != 0). There is no same-cycle pass-through: a group pushed at edge k is visible at the outputs from edge k onward.
REQ-021 Output data SHALL come from storage at the read pointer, in strict FIFO order.
REQ-022 instr_if_id for lane i SHALL be forced to INST_NOP (0x00000013) whenever out_valid=0 or lane_valid_if_id[i]=0. This is the bubble.
REQ-023 lane_valid_if_id SHALL be all zeros when out_valid=0.
REQ-024 instr_addr_if_id SHALL NOT be forced and SHALL show the stored address at the read pointer.
REQ-025 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 Pointers SHALL wrap modulo DEPTH. count SHALL saturate within 0..DEPTH; overflow and underflow are impossible by construction.
REQ-027 When flush=1 at an edge, the queue SHALL set count=0 and both pointers to 0. Any same-cycle push or pop SHALL be discarded. The next cycle shows out_valid=0 and NOP outputs.
REQ-028 flush=1 on an empty queue SHALL have no visible effect.
REQ-029 Storage contents SHALL NOT be cleared by flush; validity is governed by count only.

Reset
REQ-030 rst_sync=1 at an edge SHALL set count=0, both pointers to 0 and all storage to 0. rst_sync SHALL take priority over flush, push and pop.
REQ-031 While reset is asserted and in the first cycle after it, outputs SHALL be: in_ready=1, out_valid=0, instr_if_id=INST_NOP on every lane, instr_addr_if_id=0, lane_valid_if_id=0, count=0.
REQ-032 Reset asserted mid-operation SHALL discard all held groups, with no partial drain.

Structure
REQ-033 INST_NOP SHALL come from the shared RV32I_Inst_Pkg. Packed type fetch_group_t (instr, addr and lane_valid for LANES lanes) SHALL be added to that package.
REQ-034 Pointer and count logic SHALL live in one sub-module, if_id_queue_ctrl (push/pop/flush in; wr_ptr, rd_ptr, count out). Storage and output muxing stay in if_id_queue.

Verification
REQ-035 Reset scenario: LANES=2; assert rst_sync with in_valid=1 -> count=0, out_valid=0, both lanes 0x00000013, in_ready=1.
REQ-036 Fill and drain scenario: DEPTH=2, out_ready=0; push PC 0x100 then PC 0x108 -> count=2, in_ready=0, a third push is ignored. Raise out_ready -> outputs PC 0x100 then 0x108 in order.
REQ-037 Simultaneous push and pop scenario: count=1; push PC 0x200 while popping -> count stays 1, head becomes 0x200.
REQ-038 Flush scenario: count=2; flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, instr=NOP, and the pushed group is lost.
REQ-039 Partial group scenario: push lane_valid_if=2'b10 with instr 0x00a00093/0x00b00113 -> lane0 output NOP, lane1 output 0x00b00113, addresses unmodified.
REQ-040 Wrap-around scenario: 7 pushes and pops with random out_ready stalls at DEPTH=4 -> scoreboard shows in-order delivery with no loss or duplication.
